// File: rtl/psk_ber_checker_if.sv
// Bus bundle for psk_ber_checker: strobed Tx/Rx bit inputs, statistics clear,
// and the lock/statistics outputs. MAX_LAG must match the checker instance.
interface psk_ber_checker_if #(
   parameter int MAX_LAG = 32
) ();
   localparam int LAG_W = $clog2(MAX_LAG);

   logic             clear;
   logic             tx_bit;
   logic             tx_vld;
   logic             rx_bit;
   logic             rx_vld;
   logic [1:0]       state;
   logic             locked;
   logic [LAG_W-1:0] lag;
   logic             polarity;
   logic [31:0]      bit_cnt;
   logic [31:0]      err_cnt;
   logic [15:0]      loss_cnt;

   modport master (
      output clear, tx_bit, tx_vld, rx_bit, rx_vld,
      input  state, locked, lag, polarity, bit_cnt, err_cnt, loss_cnt
   );

   modport slave (
      input  clear, tx_bit, tx_vld, rx_bit, rx_vld,
      output state, locked, lag, polarity, bit_cnt, err_cnt, loss_cnt
   );
endinterface

// File: rtl/psk_ber_checker.sv
// PSK bit-error-rate checker (16.384 MHz domain).
// Keeps a Tx bit history, searches for the Tx->Rx lag window by window, locks
// on a clean window and then accumulates saturating bit/error statistics.
// Optional build macro PSK_BER_CHECK_POLARITY_EN: each lag is also tried with
// inverted Rx to resolve the 180-degree phase ambiguity.
module psk_ber_checker #(
   parameter int MAX_LAG  = 32,
   parameter int WINDOW   = 64,
   parameter int LOCK_ERR = 2,
   parameter int LOSS_ERR = 16
) (
   input logic               clk_16M384,
   input logic               rst_16M384,
   psk_ber_checker_if.slave  bus
);
   localparam int LAG_W  = $clog2(MAX_LAG);
   localparam int WIN_W  = $clog2(WINDOW);
   localparam int FILL_W = $clog2(MAX_LAG + 1);

   localparam logic [LAG_W-1:0]  LAG_LAST  = LAG_W'(MAX_LAG - 1);
   localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(MAX_LAG - 1);
   localparam logic [WIN_W:0]    LOCK_THR  = (WIN_W+1)'(LOCK_ERR);
   localparam logic [WIN_W:0]    LOSS_THR  = (WIN_W+1)'(LOSS_ERR);

   typedef enum logic [1:0] {
      S_FILL   = 2'd0,
      S_SEARCH = 2'd1,
      S_LOCKED = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [LAG_W-1:0]   lag_q, lag_d, lag_inc;
   logic               pol_q, pol_d;
   logic [MAX_LAG-1:0] hist;
   logic [FILL_W-1:0]  fill_cnt;
   logic [WIN_W-1:0]   win_cnt;
   logic [WIN_W:0]     win_err, win_total;
   logic               err, win_end, loss_inc;
   logic [31:0]        bit_cnt, err_cnt;
   logic [15:0]        loss_cnt;

   // Error of the current Rx bit against the pre-shift history at the candidate lag
   always_comb begin
      err       = bus.rx_bit ^ hist[lag_q] ^ pol_q;
      win_end   = bus.rx_vld && (state_q != S_FILL) && (win_cnt == WIN_LAST);
      win_total = win_err + {{WIN_W{1'b0}}, err};
      lag_inc   = (lag_q == LAG_LAST) ? '0 : lag_q + 1'b1;
   end

   // Next-state logic: fill, lag search (optionally two polarities per lag), lock/loss
   always_comb begin
      state_d  = state_q;
      lag_d    = lag_q;
      pol_d    = pol_q;
      loss_inc = 1'b0;
      case (state_q)
         S_FILL: begin
            if (bus.tx_vld && fill_cnt == FILL_LAST) begin
               state_d = S_SEARCH;
               lag_d   = '0;
            end
         end
         S_SEARCH: begin
            if (win_end) begin
               if (win_total <= LOCK_THR) begin
                  state_d = S_LOCKED;
               end else begin
`ifdef PSK_BER_CHECK_POLARITY_EN
                  // Normal polarity failed: retry this lag inverted before moving on
                  if (!pol_q) begin
                     pol_d = 1'b1;
                  end else begin
                     pol_d = 1'b0;
                     lag_d = lag_inc;
                  end
`else
                  lag_d = lag_inc;
`endif
               end
            end
         end
         S_LOCKED: begin
            if (win_end && win_total > LOSS_THR) begin
               state_d  = S_SEARCH;
               lag_d    = lag_inc;
               pol_d    = 1'b0;
               loss_inc = 1'b1;
            end
         end
         default: begin
            state_d = S_FILL;
            lag_d   = '0;
            pol_d   = 1'b0;
         end
      endcase
   end

   // State, lag and polarity registers
   always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
      if (rst_16M384) begin
         state_q <= S_FILL;
         lag_q   <= '0;
         pol_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lag_q   <= lag_d;
         pol_q   <= pol_d;
      end
   end

   // Tx history shift (newest bit in hist[0]) and fill strobe counter
   always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
      if (rst_16M384) begin
         hist     <= '0;
         fill_cnt <= '0;
      end else begin
         if (bus.tx_vld) hist <= {hist[MAX_LAG-2:0], bus.tx_bit};
         if (bus.tx_vld && state_q == S_FILL) fill_cnt <= fill_cnt + 1'b1;
      end
   end

   // Evaluation window: bit and error accumulation, cleared after the closing bit
   always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
      if (rst_16M384) begin
         win_cnt <= '0;
         win_err <= '0;
      end else if (state_q == S_FILL) begin
         win_cnt <= '0;
         win_err <= '0;
      end else if (bus.rx_vld) begin
         if (win_end) begin
            win_cnt <= '0;
            win_err <= '0;
         end else begin
            win_cnt <= win_cnt + 1'b1;
            win_err <= win_total;
         end
      end
   end

   // Saturating statistics; clear takes priority over a same-cycle increment
   always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
      if (rst_16M384) begin
         bit_cnt  <= '0;
         err_cnt  <= '0;
         loss_cnt <= '0;
      end else if (bus.clear) begin
         bit_cnt  <= '0;
         err_cnt  <= '0;
         loss_cnt <= '0;
      end else begin
         if (bus.rx_vld && state_q == S_LOCKED) begin
            if (bit_cnt != '1)        bit_cnt <= bit_cnt + 1'b1;
            if (err && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
         end
         if (loss_inc && loss_cnt != '1) loss_cnt <= loss_cnt + 1'b1;
      end
   end

   assign bus.state    = state_q;
   assign bus.locked   = (state_q == S_LOCKED);
   assign bus.lag      = lag_q;
   assign bus.polarity = pol_q;
   assign bus.bit_cnt  = bit_cnt;
   assign bus.err_cnt  = err_cnt;
   assign bus.loss_cnt = loss_cnt;
endmodule

// File: tb/tb_psk_ber_checker.sv
// Testbench for psk_ber_checker: PRBS7 Tx, Rx derived from the bench's own Tx
// history at a fixed delay of 5 strobes, scoreboarded statistics.
module tb_psk_ber_checker;
   localparam int MAX_LAG = 32;
   localparam int WINDOW  = 64;
   localparam int DELAY   = 5;
`ifdef PSK_BER_CHECK_POLARITY_EN
   localparam int NWIN_LOCK  = 2 * DELAY + 1;  // two windows per failing lag
   localparam int NWIN_SWEEP = 2 * MAX_LAG;
`else
   localparam int NWIN_LOCK  = DELAY + 1;
   localparam int NWIN_SWEEP = MAX_LAG;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   psk_ber_checker_if #(.MAX_LAG(MAX_LAG)) bif ();

   psk_ber_checker #(.MAX_LAG(MAX_LAG), .WINDOW(WINDOW), .LOCK_ERR(2), .LOSS_ERR(16)) dut (
      .clk_16M384 (clk),
      .rst_16M384 (rst),
      .bus        (bif)
   );

   typedef struct {
      logic [31:0] bits;
      logic [31:0] errs;
   } cnt_t;

   typedef struct {
      int          n;
      int          every;      // flip one Rx bit in every 'every' (0 = none)
      logic [31:0] exp_bits;
      logic [31:0] exp_errs;
      logic        exp_locked;
   } vec_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [6:0]  prbs  = 7'h7F;
   bit          txh[$];
   bit          invert = 1'b0;
   bit          sb_on  = 1'b0;
   logic [31:0] exp_bits, exp_errs;
   cnt_t        sbq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic bit prbs_next();
      bit b;
      b    = prbs[6] ^ prbs[5];
      prbs = {prbs[5:0], b};
      return b;
   endfunction

   // One Tx strobe, then an Rx strobe period-2 idle cycles later. Rx is the Tx
   // bit from DELAY strobes ago (or random), optionally flipped/inverted.
   task automatic strobe(input int period, input bit flip, input bit clr, input bit rnd);
      bit   b;
      cnt_t e;
      b = prbs_next();
      txh.push_front(b);
      if (txh.size() > 16) void'(txh.pop_back());
      bif.tx_bit = b;
      bif.tx_vld = 1'b1;
      cyc();
      bif.tx_vld = 1'b0;
      repeat (period - 2) cyc();
      bif.rx_bit = rnd ? 1'($urandom) : (txh[DELAY] ^ flip ^ invert);
      bif.rx_vld = 1'b1;
      bif.clear  = clr;
      if (clr) begin
         exp_bits = 0;
         exp_errs = 0;
      end else if (sb_on) begin
         exp_bits = exp_bits + 1;
         exp_errs = exp_errs + 32'(flip);
      end
      if (sb_on || clr) sbq.push_back('{exp_bits, exp_errs});
      cyc();
      bif.rx_vld = 1'b0;
      bif.clear  = 1'b0;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk("sb_bit_cnt", bif.bit_cnt, e.bits);
         chk("sb_err_cnt", bif.err_cnt, e.errs);
      end
   endtask

   task automatic fill_and_lock(input int period);
      int n_lock;
      n_lock = MAX_LAG + WINDOW * NWIN_LOCK - 1;
      chk("fill_state0", 32'(bif.state), 32'd0);
      for (int i = 1; i <= n_lock; i++) begin
         strobe(period, 1'b0, 1'b0, 1'b0);
         if (i == MAX_LAG - 1) chk("fill_before_last", 32'(bif.state), 32'd0);
         if (i == MAX_LAG) begin
            chk("search_entry", 32'(bif.state), 32'd1);
            chk("search_lag0", 32'(bif.lag), 32'd0);
         end
         if (i == MAX_LAG + WINDOW - 1) begin
`ifdef PSK_BER_CHECK_POLARITY_EN
            chk("win1_lag", 32'(bif.lag), 32'd0);
            chk("win1_pol", 32'(bif.polarity), 32'd1);
`else
            chk("win1_lag", 32'(bif.lag), 32'd1);
`endif
         end
         if (i == n_lock - 1) begin
            chk("prelock_state", 32'(bif.state), 32'd1);
            chk("prelock_lag", 32'(bif.lag), 32'(DELAY));
         end
      end
      chk("lock_state", 32'(bif.state), 32'd2);
      chk("lock_locked", 32'(bif.locked), 32'd1);
      chk("lock_lag", 32'(bif.lag), 32'(DELAY));
      chk("lock_pol", 32'(bif.polarity), 32'd0);
      chk("lock_bit_cnt", bif.bit_cnt, 32'd0);
      chk("lock_err_cnt", bif.err_cnt, 32'd0);
   endtask

   initial begin
      #20_000_000;
      $display("FAIL watchdog: simulation did not complete, n_cmp=%0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t tbl[4];
      int   guard;
      tbl[0] = '{1,    0,   32'd1,     32'd0,   1'b1};
      tbl[1] = '{3000, 100, 32'd3001,  32'd30,  1'b1};
      tbl[2] = '{7000, 100, 32'd10001, 32'd100, 1'b1};
      tbl[3] = '{640,  5,   32'd10641, 32'd228, 1'b1};  // <=13 errors per window: stays locked

      for (int i = 0; i < 16; i++) txh.push_front(1'b0);
      bif.clear = 0; bif.tx_bit = 0; bif.tx_vld = 0; bif.rx_bit = 0; bif.rx_vld = 0;
      exp_bits = 0; exp_errs = 0;
      rst = 1'b1;
      cyc(); cyc();
      chk("rst_state", 32'(bif.state), 32'd0);
      chk("rst_locked", 32'(bif.locked), 32'd0);
      chk("rst_lag", 32'(bif.lag), 32'd0);
      chk("rst_bit_cnt", bif.bit_cnt, 32'd0);
      chk("rst_loss_cnt", 32'(bif.loss_cnt), 32'd0);
      rst = 1'b0;
      cyc();

      // Fill and lock at a sparse strobe rate
      fill_and_lock(8);

      // Table-driven error counting while locked
      sb_on = 1'b1;
      exp_bits = 0; exp_errs = 0;
      for (int v = 0; v < 4; v++) begin
         for (int i = 0; i < tbl[v].n; i++)
            strobe(3, (tbl[v].every != 0) && (i % tbl[v].every == tbl[v].every - 1), 1'b0, 1'b0);
         chk("tbl_bit_cnt", bif.bit_cnt, tbl[v].exp_bits);
         chk("tbl_err_cnt", bif.err_cnt, tbl[v].exp_errs);
         chk("tbl_locked", 32'(bif.locked), 32'(tbl[v].exp_locked));
         chk("tbl_loss_cnt", 32'(bif.loss_cnt), 32'd0);
      end

      // Clear in the same cycle as an erroneous Rx strobe
      strobe(3, 1'b1, 1'b1, 1'b0);
      chk("clr_state", 32'(bif.state), 32'd2);
      chk("clr_loss_cnt", 32'(bif.loss_cnt), 32'd0);
      for (int i = 0; i < 10; i++) strobe(3, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset between edges while locked
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("arst_state", 32'(bif.state), 32'd0);
      chk("arst_locked", 32'(bif.locked), 32'd0);
      chk("arst_lag", 32'(bif.lag), 32'd0);
      chk("arst_pol", 32'(bif.polarity), 32'd0);
      chk("arst_bit_cnt", bif.bit_cnt, 32'd0);
      chk("arst_err_cnt", bif.err_cnt, 32'd0);
      chk("arst_loss_cnt", 32'(bif.loss_cnt), 32'd0);
      cyc();
      rst = 1'b0;
      sb_on = 1'b0;
      exp_bits = 0; exp_errs = 0;
      fill_and_lock(3);
      sb_on = 1'b1;
      for (int i = 0; i < 5; i++) strobe(3, 1'b0, 1'b0, 1'b0);
      chk("relock_bit_cnt", bif.bit_cnt, 32'd5);

      // Rx inversion while locked
      sb_on = 1'b0;
      invert = 1'b1;
      for (int i = 0; i < 2 * WINDOW; i++) strobe(3, 1'b0, 1'b0, 1'b0);
      chk("inv_lost", 32'(bif.locked), 32'd0);
      chk("inv_loss_cnt", 32'(bif.loss_cnt), 32'd1);
`ifdef PSK_BER_CHECK_POLARITY_EN
      guard = 0;
      while (!bif.locked && guard < 5000) begin
         strobe(3, 1'b0, 1'b0, 1'b0);
         guard++;
      end
      chk("inv_relock", 32'(bif.locked), 32'd1);
      chk("inv_relock_lag", 32'(bif.lag), 32'(DELAY));
      chk("inv_relock_pol", 32'(bif.polarity), 32'd1);
      chk("inv_relock_loss", 32'(bif.loss_cnt), 32'd1);
`else
      guard = 0;
      for (int i = 0; i < 3 * WINDOW; i++) begin
         strobe(3, 1'b0, 1'b0, 1'b0);
         if (bif.locked) guard++;
      end
      chk("inv_never_relock", 32'(guard), 32'd0);
      chk("inv_state", 32'(bif.state), 32'd1);
      chk("inv_loss_cnt2", 32'(bif.loss_cnt), 32'd1);
      chk("inv_pol", 32'(bif.polarity), 32'd0);
`endif
      invert = 1'b0;

      // Rx independent of Tx: lag sweeps all candidates and wraps, no lock
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      for (int s = 1; s <= MAX_LAG - 1 + WINDOW * NWIN_SWEEP; s++) begin
         strobe(3, 1'b0, 1'b0, 1'b1);
         if (s >= MAX_LAG + WINDOW - 1 && (s - (MAX_LAG - 1)) % WINDOW == 0) begin
`ifdef PSK_BER_CHECK_POLARITY_EN
            chk("sweep_lag", 32'(bif.lag), 32'((((s - (MAX_LAG - 1)) / WINDOW) / 2) % MAX_LAG));
            chk("sweep_pol", 32'(bif.polarity), 32'(((s - (MAX_LAG - 1)) / WINDOW) % 2));
`else
            chk("sweep_lag", 32'(bif.lag), 32'(((s - (MAX_LAG - 1)) / WINDOW) % MAX_LAG));
`endif
            chk("sweep_unlocked", 32'(bif.locked), 32'd0);
         end
      end
      chk("sweep_wrap_lag", 32'(bif.lag), 32'd0);
      chk("sweep_bit_cnt", bif.bit_cnt, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
